// File: rtl/pfs_fetch_queue_pkg.sv
// Shared constants and types for the pre-IF fetch queue: bus widths, reset PC,
// redirect bus layout and redirect source selection.
package pfs_fetch_queue_pkg;

   localparam int unsigned PFS_TO_FS_BUS_WD = 64;
   localparam logic [31:0] PFS_RESET_PC     = 32'h1c000000;

   // Redirect bus layout: {valid, target[31:0]}
   localparam int unsigned REDIR_TARGET_LSB = 0;
   localparam int unsigned REDIR_VALID_BIT  = 32;
   localparam int unsigned REDIR_BUS_WD     = 33;

   typedef enum logic [1:0] {
      REDIR_NONE,
      REDIR_EXC,
      REDIR_ERTN,
      REDIR_BR
   } redir_src_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fs_entry_t;

   function automatic redir_src_e redir_select(input logic exc, input logic ertn, input logic br);
      if (exc)       return REDIR_EXC;
      else if (ertn) return REDIR_ERTN;
      else if (br)   return REDIR_BR;
      else           return REDIR_NONE;
   endfunction

endpackage

// File: rtl/pfs_sync_fifo.sv
// Synchronous FIFO with clear, simultaneous push/pop at full or empty, and
// occupancy count. Depth need not be a power of two.
module pfs_sync_fifo #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // A pop frees the slot a same-cycle push needs when full
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/pfs_fetch_queue.sv
// Pre-IF fetch queue: pipelined inst_sram requests, PC tagging, cancel-counter redirects
// and an instruction buffer feeding IF. Define PFS_PERF_CNT_EN to add perf counters.
module pfs_fetch_queue
   import pfs_fetch_queue_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned IBUF_DEPTH      = 4,
   parameter logic [31:0] RESET_PC        = PFS_RESET_PC
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        br_taken,
   input  logic                        br_stall,
   input  logic [31:0]                 br_target,
   input  logic                        wb_exc,
   input  logic                        wb_ertn,
   input  logic [31:0]                 exc_entry,
   input  logic [31:0]                 exc_retaddr,
   input  logic                        fs_allowin,
   output logic                        pfs_to_fs_valid,
   output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
   output logic                        inst_sram_req,
   output logic                        inst_sram_wr,
   output logic [1:0]                  inst_sram_size,
   output logic [3:0]                  inst_sram_wstrb,
   output logic [31:0]                 inst_sram_addr,
   output logic [31:0]                 inst_sram_wdata,
   input  logic                        inst_sram_addr_ok,
   input  logic                        inst_sram_data_ok,
   input  logic [31:0]                 inst_sram_rdata
`ifdef PFS_PERF_CNT_EN
   ,
   output logic [31:0]                 perf_fetch_cnt,
   output logic [31:0]                 perf_cancel_cnt
`endif
);

   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned QW = $clog2(IBUF_DEPTH + 1);
   localparam int unsigned SW = QW + 1;

   logic [31:0]             fetch_pc_q, fetch_pc_d;
   logic [OW-1:0]           cancel_q, cancel_d;
   logic [OW-1:0]           tag_count, outstanding_next;
   logic                    tag_full, tag_empty;
   logic [31:0]             tag_pc;
   logic [QW-1:0]           ibuf_count;
   logic                    ibuf_empty, ibuf_full_unused;
   fs_entry_t               ibuf_wdata, ibuf_head;
   logic [SW-1:0]           resv_sum;
   logic [REDIR_BUS_WD-1:0] redir_bus;
   redir_src_e              redir_src;
   logic                    redir_v;
   logic [31:0]             redir_target;
   logic                    addr_acc, resp_v, resp_keep, resp_drop, fs_pop;

   always_comb begin
      redir_bus = '0;
      redir_src = redir_select(wb_exc, wb_ertn, br_taken && !br_stall);
      unique case (redir_src)
         REDIR_EXC:  redir_bus = {1'b1, exc_entry};
         REDIR_ERTN: redir_bus = {1'b1, exc_retaddr};
         REDIR_BR:   redir_bus = {1'b1, br_target};
         default:    redir_bus = '0;
      endcase
   end

   assign redir_v      = redir_bus[REDIR_VALID_BIT];
   assign redir_target = redir_bus[REDIR_TARGET_LSB +: 32];

   // Slots are reserved at issue time, so a returning response always fits in the queue
   assign resv_sum      = SW'(tag_count) + SW'(ibuf_count);
   assign inst_sram_req = resetn && !redir_v && !br_stall && !tag_full
                          && (resv_sum < SW'(IBUF_DEPTH));
   assign addr_acc      = inst_sram_req && inst_sram_addr_ok;

   // The tag FIFO occupancy is the outstanding-request count
   assign resp_v           = inst_sram_data_ok && !tag_empty;
   assign resp_drop        = resp_v && (cancel_q != '0);
   assign resp_keep        = resp_v && (cancel_q == '0);
   assign outstanding_next = tag_count + OW'(addr_acc) - OW'(resp_v);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      cancel_d   = cancel_q;
      if (redir_v) begin
         fetch_pc_d = redir_target;
         cancel_d   = outstanding_next;
      end else begin
         if (addr_acc)  fetch_pc_d = fetch_pc_q + 32'd4;
         if (resp_drop) cancel_d   = cancel_q - OW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_pc_q <= RESET_PC;
         cancel_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         cancel_q   <= cancel_d;
      end
   end

   pfs_sync_fifo #(
      .WIDTH (32),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk     (clk),
      .rst_n   (resetn),
      .push_i  (addr_acc),
      .pop_i   (resp_v),
      .clear_i (1'b0),
      .data_i  (fetch_pc_q),
      .data_o  (tag_pc),
      .full_o  (tag_full),
      .empty_o (tag_empty),
      .count_o (tag_count)
   );

   assign ibuf_wdata = {inst_sram_rdata, tag_pc};
   assign fs_pop     = pfs_to_fs_valid && fs_allowin;

   pfs_sync_fifo #(
      .WIDTH (PFS_TO_FS_BUS_WD),
      .DEPTH (IBUF_DEPTH)
   ) u_ibuf (
      .clk     (clk),
      .rst_n   (resetn),
      .push_i  (resp_keep),
      .pop_i   (fs_pop),
      .clear_i (redir_v),
      .data_i  (ibuf_wdata),
      .data_o  (ibuf_head),
      .full_o  (ibuf_full_unused),
      .empty_o (ibuf_empty),
      .count_o (ibuf_count)
   );

   assign pfs_to_fs_valid = !ibuf_empty && !(wb_exc || wb_ertn);
   assign pfs_to_fs_bus   = ibuf_empty ? '0 : ibuf_head;

   assign inst_sram_addr  = fetch_pc_q;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = 4'b0000;
   assign inst_sram_wdata = 32'h0;

`ifdef PFS_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_cancel_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_fetch_q  <= '0;
         perf_cancel_q <= '0;
      end else begin
         if (addr_acc)  perf_fetch_q  <= perf_fetch_q + 32'd1;
         if (resp_drop) perf_cancel_q <= perf_cancel_q + 32'd1;
      end
   end

   assign perf_fetch_cnt  = perf_fetch_q;
   assign perf_cancel_cnt = perf_cancel_q;
`endif

endmodule

// File: tb/tb_pfs_fetch_queue.sv
// Randomised bench for pfs_fetch_queue against a queue-based reference model
// of the fetch/cancel/buffer rules, with a simple in-order inst_sram emulator.
module tb_pfs_fetch_queue;

   localparam int unsigned MAXO  = 2;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h1c000000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        br_taken = 1'b0, br_stall = 1'b0, wb_exc = 1'b0, wb_ertn = 1'b0;
   logic [31:0] br_target = '0, exc_entry = '0, exc_retaddr = '0;
   logic        fs_allowin = 1'b0;
   logic        addr_ok = 1'b0, data_ok = 1'b0;
   logic [31:0] rdata = '0;
   logic        pfs_to_fs_valid;
   logic [63:0] pfs_to_fs_bus;
   logic        inst_sram_req, inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr, inst_sram_wdata;
`ifdef PFS_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_cancel_cnt;
`endif

   pfs_fetch_queue #(
      .MAX_OUTSTANDING (MAXO),
      .IBUF_DEPTH      (DEPTH),
      .RESET_PC        (RPC)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .br_taken          (br_taken),
      .br_stall          (br_stall),
      .br_target         (br_target),
      .wb_exc            (wb_exc),
      .wb_ertn           (wb_ertn),
      .exc_entry         (exc_entry),
      .exc_retaddr       (exc_retaddr),
      .fs_allowin        (fs_allowin),
      .pfs_to_fs_valid   (pfs_to_fs_valid),
      .pfs_to_fs_bus     (pfs_to_fs_bus),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_wstrb   (inst_sram_wstrb),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (addr_ok),
      .inst_sram_data_ok (data_ok),
      .inst_sram_rdata   (rdata)
`ifdef PFS_PERF_CNT_EN
      ,
      .perf_fetch_cnt    (perf_fetch_cnt),
      .perf_cancel_cnt   (perf_cancel_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   typedef struct {
      logic [31:0] pc;
      bit          cancel;
   } flight_t;

   flight_t     m_flight[$];
   logic [63:0] m_ibuf[$];
   logic [31:0] m_pc;
   logic [31:0] sram_q[$];
   logic [31:0] m_fetch, m_discard;

   int unsigned p_aok, p_dok, p_allow, p_br, p_stall, p_exc, p_ertn;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9e3779b1) ^ 32'h5a5a1234;
   endfunction

   function automatic bit chance(input int unsigned pct);
      return $urandom_range(99, 0) < pct;
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] r;
      if ($urandom_range(15, 0) == 0) r = 32'hfffffff8;
      else r = 32'h1c000000 + ({24'h0, 8'($urandom_range(255, 0))} << 2);
      return r;
   endfunction

   function automatic void model_reset();
      m_flight.delete();
      m_ibuf.delete();
      sram_q.delete();
      m_pc      = RPC;
      m_fetch   = '0;
      m_discard = '0;
   endfunction

   function automatic void set_rates(input int unsigned aok, dok, allow, br, stall, exc, ertn);
      p_aok = aok; p_dok = dok; p_allow = allow; p_br = br;
      p_stall = stall; p_exc = exc; p_ertn = ertn;
   endfunction

   task automatic step();
      bit          redir;
      logic [31:0] tgt;
      bit          e_req, e_valid;
      flight_t     f;
      @(posedge clk);
      #1;
      addr_ok     = chance(p_aok);
      data_ok     = (sram_q.size() > 0) && chance(p_dok);
      rdata       = data_ok ? mem_word(sram_q[0]) : $urandom;
      fs_allowin  = chance(p_allow);
      br_stall    = chance(p_stall);
      br_taken    = chance(p_br);
      wb_exc      = chance(p_exc);
      wb_ertn     = chance(p_ertn);
      br_target   = rand_pc();
      exc_entry   = rand_pc();
      exc_retaddr = rand_pc();
      #3;
      redir = 1'b1;
      tgt   = '0;
      if (wb_exc)                      tgt = exc_entry;
      else if (wb_ertn)                tgt = exc_retaddr;
      else if (br_taken && !br_stall)  tgt = br_target;
      else                             redir = 1'b0;
      e_req   = !redir && !br_stall && (m_flight.size() + m_ibuf.size() < DEPTH)
                && (m_flight.size() < MAXO);
      e_valid = (m_ibuf.size() > 0) && !(wb_exc || wb_ertn);
      check_val("req", 64'(inst_sram_req), 64'(e_req));
      check_val("addr", 64'(inst_sram_addr), 64'(m_pc));
      check_val("valid", 64'(pfs_to_fs_valid), 64'(e_valid));
      if (e_valid) check_val("bus", pfs_to_fs_bus, m_ibuf[0]);
      check_val("ties", 64'({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}),
                64'({1'b0, 2'b10, 4'b0000, 32'h0}));
`ifdef PFS_PERF_CNT_EN
      check_val("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fetch));
      check_val("perf_cancel", 64'(perf_cancel_cnt), 64'(m_discard));
`endif
      if (e_valid && fs_allowin) void'(m_ibuf.pop_front());
      if (data_ok) begin
         f = m_flight.pop_front();
         void'(sram_q.pop_front());
         if (f.cancel) m_discard++;
         else m_ibuf.push_back({mem_word(f.pc), f.pc});
      end
      if (e_req && addr_ok) begin
         f.pc     = m_pc;
         f.cancel = 1'b0;
         m_flight.push_back(f);
         sram_q.push_back(m_pc);
         m_pc = m_pc + 32'd4;
         m_fetch++;
      end
      if (redir) begin
         m_ibuf.delete();
         foreach (m_flight[i]) m_flight[i].cancel = 1'b1;
         m_pc = tgt;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      resetn = 1'b0;
      {br_taken, br_stall, wb_exc, wb_ertn, fs_allowin, addr_ok, data_ok} = '0;
      #2;
      check_val("rst_req", 64'(inst_sram_req), 64'(1'b0));
      check_val("rst_valid", 64'(pfs_to_fs_valid), 64'(1'b0));
      check_val("rst_addr", 64'(inst_sram_addr), 64'(RPC));
      check_val("rst_bus", pfs_to_fs_bus, 64'h0);
      check_val("rst_size", 64'(inst_sram_size), 64'(2'b10));
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();

      // Free-flowing fetch from the reset PC
      set_rates(100, 100, 100, 0, 0, 0, 0);
      repeat (10) step();

      // IF stalled: queue fills to IBUF_DEPTH, then issue stops
      set_rates(100, 100, 0, 0, 0, 0, 0);
      repeat (12) step();
      check_val("fill_req", 64'(inst_sram_req), 64'(1'b0));
      check_val("fill_valid", 64'(pfs_to_fs_valid), 64'(1'b1));
      set_rates(100, 100, 100, 0, 0, 0, 0);
      repeat (4) step();

      // Branch with two requests in flight, slow responses
      set_rates(100, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
      set_rates(100, 0, 0, 100, 0, 0, 0);
      step();
      set_rates(100, 100, 100, 0, 0, 0, 0);
      repeat (8) step();

      // Exception and branch together
      set_rates(100, 100, 0, 100, 0, 100, 0);
      step();
      set_rates(100, 100, 100, 0, 0, 0, 0);
      repeat (6) step();

      // Branch held under stall, then released
      set_rates(100, 100, 100, 100, 100, 0, 0);
      repeat (3) step();
      set_rates(100, 100, 100, 100, 0, 0, 0);
      step();
      set_rates(100, 100, 100, 0, 0, 0, 0);
      repeat (6) step();

      // Randomised traffic with varying event probabilities
      for (int blk = 0; blk < 20; blk++) begin
         set_rates($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(100, 10),
                   $urandom_range(15, 0), $urandom_range(30, 0),
                   $urandom_range(5, 0), $urandom_range(5, 0));
         repeat (150) step();
         if (blk == 10) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
